mmcm_drp_sequencer: RTL
=======================

// Module: mmcm_drp_sequencer
// PURPOSE
//  Runtime reconfiguration controller for the display MMCM (MMCME2_ADV DRP port).
//  On a start request it holds the MMCM in reset and applies NUM_REGS masked
//  read-modify-write DRP accesses from an external config table.
//  It then releases reset, waits for a synchronized LOCKED and reports done or error.
//  Downstream pixel logic gates its reset with clk_ok_out.
// PARAMETERS
//  NUM_REGS      23    config table entries applied per reconfiguration (>=1)
//  RST_HOLD      8     cycles mmcm_rst_out held high before first DRP access (>=1)
//  DRP_TIMEOUT   64    max cycles waiting for drp_rdy_in per access
//  LOCK_TIMEOUT  65536 max cycles waiting for synchronized lock after release
// PORTS
//  clk_in          in   1   DRP/control clock (also DCLK of the MMCM)
//  rstn_in         in   1   async active-low reset
//  start_in        in   1   1-cycle pulse: begin reconfiguration (ignored unless IDLE)
//  busy_out        out  1   high from accepted start until done/error
//  done_out        out  1   1-cycle pulse: reconfig complete, MMCM locked
//  error_out       out  1   sticky: DRP or lock timeout; cleared by next accepted start
//  clk_ok_out      out  1   synchronized lock AND state==IDLE AND !error_out
//  cfg_idx_out     out  $clog2(NUM_REGS)  table entry index being applied
//  cfg_entry_in    in   39  {drp_addr[38:32], mask[31:16], value[15:0]}, comb. from cfg_idx_out
//  drp_addr_out    out  7   DADDR
//  drp_di_out      out  16  DI
//  drp_do_in       in   16  DO
//  drp_en_out      out  1   DEN (single-cycle pulse)
//  drp_we_out      out  1   DWE (only with drp_en_out)
//  drp_rdy_in      in   1   DRDY
//  mmcm_rst_out    out  1   MMCM RST
//  mmcm_locked_in  in   1   MMCM LOCKED (asynchronous; 2-flop synchronized internally)
// BEHAVIOUR
//  Reset values: state=HOLD, mmcm_rst_out=1, busy_out=0, done_out=0, error_out=0.
//   clk_ok_out=0; drp_en/we=0; drp_addr/di=0; cfg_idx_out=0; counters=0; lock sync=0.
//  After reset: HOLD->RELEASE->WAIT_LOCK with power-on config, no DRP writes, busy_out=0.
//   Lock in this path -> IDLE, no done pulse.
//  FSM: IDLE -start-> HOLD (mmcm_rst_out=1, error cleared, cfg_idx=0, busy=1).
//  HOLD: count RST_HOLD cycles -> RD (or RELEASE if post-reset path).
//  RD: drive drp_addr=entry.addr, drp_en=1 one cycle -> RD_WAIT.
//  RD_WAIT: on drp_rdy_in capture drp_do_in -> WR.
//   After DRP_TIMEOUT cycles without it -> ERR.
//  WR: drp_di=(rd & ~mask)|(value & mask); drp_en=drp_we=1 one cycle -> WR_WAIT.
//  WR_WAIT: on drp_rdy_in: last entry -> RELEASE, else cfg_idx+1 -> RD.
//   After DRP_TIMEOUT cycles -> ERR.
//  RELEASE: mmcm_rst_out<=0 -> WAIT_LOCK.
//  WAIT_LOCK: sync lock high -> IDLE with done_out pulse (busy=0 same edge).
//   After LOCK_TIMEOUT cycles -> ERR.
//  ERR: error_out<=1, busy<=0, mmcm_rst_out stays 0 -> IDLE. Retry is by next start.
//  Timeout counters reset on every state entry; the timeout cycle count is exact.
//  drp_rdy_in outside RD_WAIT/WR_WAIT: ignored. start_in when not IDLE: ignored.
//  Lock loss while IDLE: clk_ok_out drops 2 cycles later; no FSM action.
//  rstn_in low mid-operation: immediate return to reset values. A DRP access may be cut off.
//   The MMCM is held in reset, so any partial config is recovered by the next start.
// TESTING
//  Reset, lock model asserts 20 cycles after release -> clk_ok_out=1, done_out never pulses.
//  start, NUM_REGS=2; entry0 {07,FF00,1234}; DO returns ABCD; DRDY latency 3.
//   -> first write DI=12CD, DWE with DEN only.
//   -> RST high for 8+ cycles before the first DEN.
//   -> done_out one pulse after lock.
//  DRDY never returns -> error_out=1 exactly DRP_TIMEOUT cycles after RD_WAIT entry.
//   -> busy=0, clk_ok_out=0; next start clears error_out.
//  Lock never returns -> error_out after LOCK_TIMEOUT; mmcm_rst_out=0.
//  start during busy and spurious DRDY in IDLE -> no state change, no extra DEN.
//  rstn_in low during WR_WAIT -> all outputs at reset values.
//   -> mmcm_rst_out=1 next edge; no done_out.

Source files
------------

// File: rtl/mmcm_drp_sequencer.sv
// Runtime MMCME2_ADV reconfiguration: holds the MMCM in reset, applies masked
// read-modify-write DRP accesses from an external table, then waits for lock.
module mmcm_drp_sequencer #(
  parameter int unsigned NUM_REGS     = 23,
  parameter int unsigned RST_HOLD     = 8,
  parameter int unsigned DRP_TIMEOUT  = 64,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  localparam int unsigned IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk_in,
  input  logic             rstn_in,
  input  logic             start_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             error_out,
  output logic             clk_ok_out,
  output logic [IDX_W-1:0] cfg_idx_out,
  input  logic [38:0]      cfg_entry_in,
  output logic [6:0]       drp_addr_out,
  output logic [15:0]      drp_di_out,
  input  logic [15:0]      drp_do_in,
  output logic             drp_en_out,
  output logic             drp_we_out,
  input  logic             drp_rdy_in,
  output logic             mmcm_rst_out,
  input  logic             mmcm_locked_in
);

  localparam int unsigned MAX_A   = (RST_HOLD > DRP_TIMEOUT) ? RST_HOLD : DRP_TIMEOUT;
  localparam int unsigned MAX_CNT = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] DRP_LAST  = CNT_W'(DRP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_HOLD, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_RELEASE, S_WAIT_LOCK, S_ERR
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [15:0]      r_rdata;
  logic             r_por;
  logic             r_error;
  logic             r_done;
  logic             r_lock_meta;
  logic             r_lock_sync;

  logic             w_last;
  logic             w_accept;
  logic [15:0]      w_mask;
  logic [15:0]      w_value;
  logic [15:0]      w_merge;
  logic             w_rst;
  logic             w_busy;
  logic             w_den;
  logic             w_dwe;
  logic [6:0]       w_addr;
  logic [15:0]      w_di;

  assign w_last   = (r_idx == IDX_LAST);
  assign w_accept = (r_state == S_IDLE) && start_in;
  assign w_mask   = cfg_entry_in[31:16];
  assign w_value  = cfg_entry_in[15:0];
  assign w_merge  = (r_rdata & ~w_mask) | (w_value & w_mask);

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) r_state <= S_HOLD;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (start_in) w_state_nxt = S_HOLD;
      // r_por marks the power-on pass: the MMCM boots its own config, so skip DRP
      S_HOLD:      if (r_cnt == HOLD_LAST) w_state_nxt = r_por ? S_RELEASE : S_RD;
      S_RD:        w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: begin
        if (drp_rdy_in)              w_state_nxt = S_WR;
        else if (r_cnt == DRP_LAST)  w_state_nxt = S_ERR;
      end
      S_WR:        w_state_nxt = S_WR_WAIT;
      S_WR_WAIT: begin
        if (drp_rdy_in)              w_state_nxt = w_last ? S_RELEASE : S_RD;
        else if (r_cnt == DRP_LAST)  w_state_nxt = S_ERR;
      end
      S_RELEASE:   w_state_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (r_lock_sync)             w_state_nxt = S_IDLE;
        else if (r_cnt == LOCK_LAST) w_state_nxt = S_ERR;
      end
      S_ERR:       w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_HOLD;
    endcase
  end

  always_comb begin
    w_rst  = 1'b0;
    w_busy = 1'b0;
    w_den  = 1'b0;
    w_dwe  = 1'b0;
    case (r_state)
      S_HOLD, S_RD_WAIT, S_WR_WAIT, S_RELEASE: begin
        w_rst  = 1'b1;
        w_busy = !r_por;
      end
      S_RD: begin
        w_rst  = 1'b1;
        w_busy = !r_por;
        w_den  = 1'b1;
      end
      S_WR: begin
        w_rst  = 1'b1;
        w_busy = !r_por;
        w_den  = 1'b1;
        w_dwe  = 1'b1;
      end
      S_WAIT_LOCK: w_busy = !r_por;
      default: ;
    endcase
    w_addr = w_den ? cfg_entry_in[38:32] : '0;
    w_di   = w_dwe ? w_merge : '0;
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rdata     <= '0;
      r_por       <= 1'b1;
      r_error     <= 1'b0;
      r_done      <= 1'b0;
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= mmcm_locked_in;
      r_lock_sync <= r_lock_meta;

      if (w_state_nxt != r_state || r_state == S_IDLE) r_cnt <= '0;
      else                                             r_cnt <= r_cnt + CNT_W'(1);

      if (w_state_nxt == S_IDLE) r_por <= 1'b0;

      if (w_accept)
        r_idx <= '0;
      else if (r_state == S_WR_WAIT && drp_rdy_in && !w_last)
        r_idx <= r_idx + IDX_W'(1);

      if (r_state == S_RD_WAIT && drp_rdy_in) r_rdata <= drp_do_in;

      if (w_accept)                  r_error <= 1'b0;
      else if (w_state_nxt == S_ERR) r_error <= 1'b1;

      r_done <= (r_state == S_WAIT_LOCK) && r_lock_sync && !r_por;
    end
  end

  assign busy_out     = w_busy;
  assign done_out     = r_done;
  assign error_out    = r_error;
  assign clk_ok_out   = r_lock_sync && (r_state == S_IDLE) && !r_error;
  assign cfg_idx_out  = r_idx;
  assign drp_addr_out = w_addr;
  assign drp_di_out   = w_di;
  assign drp_en_out   = w_den;
  assign drp_we_out   = w_dwe;
  assign mmcm_rst_out = w_rst;

endmodule
